// File: rtl/dma_dat_row_notify_pkg.sv
// Shared widths and state encoding for the DMA feature-row completion tracker.
// Row/beat widths come from the project-wide defines, with fallbacks when absent.
`ifndef log2_H
`define log2_H 8
`endif
`ifndef log2_BEATS
`define log2_BEATS 4
`endif

package dma_dat_row_notify_pkg;

   localparam int H_W     = `log2_H;
   localparam int BEATS_W = `log2_BEATS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A zero beats-per-row setting behaves like one beat per row.
   function automatic logic [BEATS_W-1:0] last_beat_idx(input logic [BEATS_W-1:0] beats);
      return (beats == '0) ? '0 : beats - 1'b1;
   endfunction

endpackage

// File: rtl/dma_dat_row_notify.sv
// Counts DMA beats landing in the feature buffer and pulses row_num_updt for each
// completed row; flags dma_dat_done when the layer is complete or reused.
module dma_dat_row_notify
   import dma_dat_row_notify_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fsm_logic_init,
   input  logic                   dma_dat_reuse,
   input  logic [`log2_H-1:0]     Hin,
   input  logic [`log2_BEATS-1:0] row_beats,
   input  logic                   dma_wr_vld,
   output logic                   dma_wr_rdy,
   output logic                   row_num_updt,
   output logic [`log2_H-1:0]     row_num,
   output logic                   dma_dat_done
);

   state_t                 r_state;
   logic [`log2_BEATS-1:0] r_beat_cnt;
   logic [`log2_H-1:0]     r_row_cnt;
   logic [`log2_H-1:0]     r_row_num;
   logic                   r_row_num_updt;
   logic                   r_dma_dat_done;

   logic                   w_rows_left;
   logic                   w_row_end;
   logic                   w_accept;
   logic [`log2_H-1:0]     w_row_cnt_inc;

   // Only a zero-row layer can sit in RUN with no rows left; refuse beats there
   // so nothing is accepted that would never be counted.
   assign w_rows_left   = (r_row_cnt != Hin);
   assign w_row_end     = (r_beat_cnt == last_beat_idx(row_beats));
   assign w_row_cnt_inc = r_row_cnt + 1'b1;
   assign dma_wr_rdy    = (r_state == ST_RUN) & ~fsm_logic_init & ~rst & w_rows_left;
   assign w_accept      = dma_wr_vld & dma_wr_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_beat_cnt     <= '0;
         r_row_cnt      <= '0;
         r_row_num      <= '0;
         r_row_num_updt <= 1'b0;
         r_dma_dat_done <= 1'b0;
      end else begin
         r_row_num_updt <= 1'b0;
         if (fsm_logic_init) begin
            if (dma_dat_reuse) begin
               r_state        <= ST_DONE;
               r_dma_dat_done <= 1'b1;
            end else begin
               r_state        <= ST_RUN;
               r_dma_dat_done <= 1'b0;
               r_beat_cnt     <= '0;
               r_row_cnt      <= '0;
               r_row_num      <= '0;
            end
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (!w_rows_left) begin
                     r_state        <= ST_DONE;
                     r_dma_dat_done <= 1'b1;
                  end else if (w_accept) begin
                     if (w_row_end) begin
                        r_beat_cnt     <= '0;
                        r_row_cnt      <= w_row_cnt_inc;
                        r_row_num      <= r_row_cnt;
                        r_row_num_updt <= 1'b1;
                        if (w_row_cnt_inc == Hin) begin
                           r_state        <= ST_DONE;
                           r_dma_dat_done <= 1'b1;
                        end
                     end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign row_num_updt = r_row_num_updt;
   assign row_num      = r_row_num;
   assign dma_dat_done = r_dma_dat_done;

endmodule

// File: doc/dma_dat_row_notify.md
DMA_DAT_ROW_NOTIFY -- requirements
Module: dma_dat_row_notify

Interface
REQ-001 SHALL take shared widths from CNN_defines.vh: `log2_H` for row indices and new `log2_BEATS` for the beats-per-row field; no local width parameters.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 fsm_logic_init  input  1  CSR layer-start pulse.
REQ-005 dma_dat_reuse  input  1  CSR flag: feature buffer already holds this layer's data.
REQ-006 Hin  input  `log2_H  rows in the layer.
REQ-007 row_beats  input  `log2_BEATS  DMA write beats per buffer row.
REQ-008 dma_wr_vld  input  1  DMA has a beat landing in the feature buffer.
REQ-009 dma_wr_rdy  output  1  beat accepted when dma_wr_vld & dma_wr_rdy.
REQ-010 row_num_updt  output  1  one-cycle pulse: a full row has landed.
REQ-011 row_num  output  `log2_H  index of the most recently completed row; valid with row_num_updt, held afterwards.
REQ-012 dma_dat_done  output  1  level: all Hin rows landed, or reuse.

Function
REQ-013 States: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on fsm_logic_init & ~dma_dat_reuse; clears beat_cnt, row_cnt, row_num.
REQ-015 Any state -> DONE on fsm_logic_init & dma_dat_reuse; row_num held, no row_num_updt issued.
REQ-016 fsm_logic_init in RUN or DONE restarts per REQ-014/015 (init has priority over everything).
REQ-017 dma_wr_rdy = (state==RUN) & ~fsm_logic_init; combinational; a beat in an init cycle is not accepted.
REQ-018 Accepted beat: beat_cnt+1; on beat_cnt == row_beats-1: beat_cnt <= 0, row_cnt+1.
REQ-019 row_beats==0 SHALL be treated as 1.
REQ-020 On the row-completing beat at edge N: row_num_updt=1 and row_num=completed row index during cycle N+1 (one-cycle latency, registered).
REQ-021 Completing row Hin-1: RUN -> DONE at the same edge; dma_wr_rdy low from then on; row_num_updt still pulses for that row.
REQ-022 Hin==0: RUN -> DONE the cycle after entry, no row_num_updt.
REQ-023 dma_dat_done = (state==DONE), registered; low in IDLE and RUN.
REQ-024 Beats offered in IDLE or DONE are back-pressured, never counted.
REQ-025 row_cnt never wraps; it stops at Hin (DONE blocks further beats).
REQ-026 row_num_updt never asserted in two consecutive cycles when row_beats>=2; back-to-back pulses legal when row_beats==1.

Reset
REQ-027 rst: state=IDLE, beat_cnt=0, row_cnt=0, row_num=0, row_num_updt=0, dma_dat_done=0, dma_wr_rdy=0.
REQ-028 rst mid-RUN discards partial row; no pulse emitted for it.
REQ-029 rst has priority over fsm_logic_init in the same cycle.

Structure
REQ-030 `log2_BEATS added to CNN_defines.vh beside `log2_H; state encodings local localparams.
REQ-031 Single flat module; no sub-module needed.

Verification
REQ-032 Hin=4, row_beats=3, vld held high -> dma_wr_rdy high 12 cycles; updt pulses after beats 3,6,9,12 with row_num 0,1,2,3; dma_dat_done high after 12th beat.
REQ-033 Hin=3, row_beats=1 -> three back-to-back updt pulses, row_num 0,1,2; rdy drops after 3rd beat.
REQ-034 init with dma_dat_reuse=1 after layer ending at row_num=5 -> DONE next cycle, row_num stays 5, no updt, rdy low.
REQ-035 Hin=2, row_beats=4, rst asserted after 2 beats -> all outputs zero next cycle; subsequent init + 8 beats yields rows 0,1 normally.
REQ-036 init and dma_wr_vld same cycle in RUN -> beat not accepted, counters cleared; Hin=0 -> DONE with no updt.
